// File: rtl/mux2_sel.sv
// mux2_sel: two-way word selector for the datapath, with a registered copy of the
// result and select-activity monitoring (change pulse plus saturating switch counter).
module mux2_sel #(
   parameter int n     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [n-1:0]     a,
   input  logic [n-1:0]     b,
   input  logic             select,
   output logic [n-1:0]     out,
   output logic [n-1:0]     out_q,
   output logic             sel_q,
   output logic             sel_changed,
   output logic [CNT_W-1:0] switch_cnt
);

   logic sel_diff;
   logic cnt_full;

   assign out      = select ? b : a;
   assign sel_diff = (select != sel_q);
   assign cnt_full = &switch_cnt;

   // The counter saturates at all-ones, but the change pulse keeps firing regardless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         sel_q       <= 1'b0;
         sel_changed <= 1'b0;
         switch_cnt  <= '0;
      end else begin
         out_q       <= out;
         sel_q       <= select;
         sel_changed <= sel_diff;
         if (sel_diff && !cnt_full)
            switch_cnt <= switch_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mux2_sel.sv
// Self-checking bench for mux2_sel: a 32-bit instance with a 2-bit counter (to reach
// saturation quickly) and an 8-bit instance, checked against a behavioural model.
module tb_mux2_sel;

   localparam int N     = 32;
   localparam int CW    = 2;
   localparam int N8    = 8;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  a, b, out, out_q;
   logic          select, sel_q, sel_changed;
   logic [CW-1:0] switch_cnt;

   logic [N8-1:0] a8, b8, out8, out_q8;
   logic          sel8, sel_q8, sel_changed8;
   logic [15:0]   switch_cnt8;

   int compares = 0;
   int errors   = 0;

   // Model state: the count of changes is unbounded; saturation is applied on compare.
   logic [N-1:0]  mOutQ;
   logic          mSelQ, mChg;
   int            mChanges;
   logic [N8-1:0] mOutQ8;

   mux2_sel #(.n(N), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .select(select),
      .out(out), .out_q(out_q), .sel_q(sel_q),
      .sel_changed(sel_changed), .switch_cnt(switch_cnt)
   );

   mux2_sel #(.n(N8)) dut8 (
      .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .select(sel8),
      .out(out8), .out_q(out_q8), .sel_q(sel_q8),
      .sel_changed(sel_changed8), .switch_cnt(switch_cnt8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compares++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vs);
      a      = va;
      b      = vb;
      select = vs;
   endtask

   function automatic int satCount(input int c);
      return (c > CMAX) ? CMAX : c;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mOutQ    = '0;
         mSelQ    = 1'b0;
         mChg     = 1'b0;
         mChanges = 0;
         mOutQ8   = '0;
      end else begin
         mChg     = (select != mSelQ);
         mChanges = mChanges + (mChg ? 1 : 0);
         mSelQ    = select;
         mOutQ    = (select == 1'b0) ? a : b;
         mOutQ8   = (sel8 == 1'b0) ? a8 : b8;
      end
   end

   // Every cycle, just after the edge, registered outputs must match the model.
   always @(posedge clk) begin
      #1;
      checkOutput("out_q",       64'(out_q),       64'(mOutQ));
      checkOutput("sel_q",       64'(sel_q),       64'(mSelQ));
      checkOutput("sel_changed", 64'(sel_changed), 64'(mChg));
      checkOutput("switch_cnt",  64'(switch_cnt),  64'(satCount(mChanges)));
      checkOutput("out",         64'(out),         64'((select == 1'b0) ? a : b));
      checkOutput("out_q8",      64'(out_q8),      64'(mOutQ8));
      checkOutput("out8",        64'(out8),        64'((sel8 == 1'b0) ? a8 : b8));
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(32'd14, 32'd16, 1'b0);
      a8 = 8'h00;
      b8 = 8'h00;
      sel8 = 1'b0;

      // Reset state; combinational path is live during reset.
      #2;
      checkOutput("rst out_q",       64'(out_q),       64'd0);
      checkOutput("rst sel_q",       64'(sel_q),       64'd0);
      checkOutput("rst sel_changed", 64'(sel_changed), 64'd0);
      checkOutput("rst switch_cnt",  64'(switch_cnt),  64'd0);
      checkOutput("rst out",         64'(out),         64'd14);

      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;
      checkOutput("lit out_q 14",    64'(out_q),       64'd14);
      checkOutput("lit changed 0",   64'(sel_changed), 64'd0);
      checkOutput("lit cnt 0",       64'(switch_cnt),  64'd0);

      // Switch to b.
      @(negedge clk) select = 1'b1;
      #1 checkOutput("lit out 16 comb", 64'(out), 64'd16);
      @(posedge clk) #1;
      checkOutput("lit out_q 16",    64'(out_q),       64'd16);
      checkOutput("lit changed 1",   64'(sel_changed), 64'd1);
      checkOutput("lit cnt 1",       64'(switch_cnt),  64'd1);
      @(posedge clk) #1;
      checkOutput("lit changed back 0", 64'(sel_changed), 64'd0);
      checkOutput("lit cnt hold 1",     64'(switch_cnt),  64'd1);

      // Data changes while select is stable.
      @(negedge clk) a = 32'd99;
      #1 checkOutput("lit out ignores a", 64'(out), 64'd16);
      b = 32'hFFFF_FFFF;
      #1 checkOutput("lit out b ones", 64'(out), 64'hFFFF_FFFF);
      @(posedge clk) #1;
      checkOutput("lit out_q ones", 64'(out_q), 64'hFFFF_FFFF);

      // Fresh reset, then toggle every cycle to drive the 2-bit counter into saturation.
      @(negedge clk) rst_n = 1'b0;
      b = 32'd16;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         select = (i % 2 == 0);
         @(posedge clk) #1;
         checkOutput("lit toggle changed", 64'(sel_changed), 64'd1);
         checkOutput("lit toggle cnt",     64'(switch_cnt),  64'((i + 1 > 3) ? 3 : i + 1));
         @(negedge clk);
      end
      checkOutput("lit pre-reset out_q", 64'(out_q), 64'd16);

      // Asynchronous reset mid-cycle.
      #2 rst_n = 1'b0;
      #1;
      checkOutput("lit async out_q",   64'(out_q),       64'd0);
      checkOutput("lit async sel_q",   64'(sel_q),       64'd0);
      checkOutput("lit async cnt",     64'(switch_cnt),  64'd0);
      checkOutput("lit async changed", 64'(sel_changed), 64'd0);
      checkOutput("lit async out",     64'(out),         64'd16);
      @(negedge clk) rst_n = 1'b1;

      // 8-bit instance alternating between two patterns.
      a8 = 8'hA5;
      b8 = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) sel8 = i[0];
         #1 checkOutput("lit out8", 64'(out8), (i % 2 == 0) ? 64'hA5 : 64'h5A);
      end
      @(posedge clk) #1;
      checkOutput("lit out_q8", 64'(out_q8), 64'h5A);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
      $finish;
   end

endmodule
